// File: rtl/counter_pkg.sv
// Shared constants and next-action encoding for
// the falling-edge modulo up counter.
package counter_pkg;

    localparam int DEF_WIDTH   = 3;
    localparam int DEF_RST_VAL = 0;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_INC  = 2'd2,
        ACT_WRAP = 2'd3
    } act_e;

endpackage

// File: rtl/cnt_next_state.sv
// Next-count decode: picks load/inc/wrap/hold
// and produces the next q value.
module cnt_next_state
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             load,
    output logic [WIDTH-1:0] q_nxt,
    output act_e             act
);

    logic hit;

    // wrap on a limit match, or on natural rollover
    // when q has been loaded past the limit
    assign hit = (q == limit) || (q == {WIDTH{1'b1}});

    // action decode; load beats enable
    always_comb begin
        act = ACT_HOLD;
        unique case (1'b1)
            load:              act = ACT_LOAD;
            (!load && en && hit):  act = ACT_WRAP;
            (!load && en && !hit): act = ACT_INC;
            (!load && !en):    act = ACT_HOLD;
        endcase
    end

    // next count from the chosen action
    always_comb begin
        q_nxt = q;
        unique case (act)
            ACT_LOAD: q_nxt = din;
            ACT_WRAP: q_nxt = '0;
            ACT_INC:  q_nxt = q + WIDTH'(1);
            ACT_HOLD: q_nxt = q;
        endcase
    end

endmodule

// File: rtl/negedge_mod_up_counter.sv
// Falling-edge loadable modulo up counter with
// combinational carry and sticky wrap flag.
module negedge_mod_up_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int RST_VAL = DEF_RST_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] limit,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] q_nxt;
    act_e             act;
    logic             wrap;

    cnt_next_state #(
        .WIDTH (WIDTH)
    ) u_next (
        .q     (q),
        .limit (limit),
        .din   (din),
        .en    (en),
        .load  (load),
        .q_nxt (q_nxt),
        .act   (act)
    );

    assign wrap = (act == ACT_WRAP);

    // carry is gated by rst so a cascade stays quiet in reset
    assign tc = rst && en && !load && (q == limit);

    // count register, falling edge, async active-low reset
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) q <= RST_Q;
        else      q <= q_nxt;
    end

    // sticky wrap flag; a wrap beats a same-edge clear
    always_ff @(negedge clk or negedge rst) begin
        if (!rst)         ovf <= 1'b0;
        else if (wrap)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

endmodule

// File: doc/negedge_mod_up_counter.md
Name: negedge_mod_up_counter

Overview:
- Falling-edge-clocked, parameterised, loadable modulo up counter; the count-up counterpart to the team's falling-edge 3-bit down counter.
- Counts from 0 up to a runtime-programmable limit, then wraps to 0.
- Provides a combinational terminal-count carry for cascading stages and a sticky wrap flag for software polling.
- Sits in the timer and sequencing area of the design, clocked by the same negedge domain as the down counter.

Parameters:
- WIDTH, 3, counter width in bits (legal 2..16).
- RST_VAL, 0, value loaded on reset; must be <= 2^WIDTH-1.

Ports:
- clk  in  1  clock; all state updates on falling edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  count enable, sampled on falling edge.
- load  in  1  synchronous parallel load, sampled on falling edge.
- din  in  WIDTH  load value.
- limit  in  WIDTH  terminal value; counter wraps after reaching it.
- ovf_clr  in  1  synchronous clear of the sticky wrap flag.
- q  out  WIDTH  current count (registered).
- tc  out  1  terminal count / carry-out (combinational).
- ovf  out  1  sticky wrap flag (registered).

Behaviour:
- Reset: rst=0 forces q=RST_VAL and ovf=0 immediately, with no clock needed. Reset holds while low. The first falling edge after rst rises performs normal operation.
- Reset mid-count: same as above. In-flight load and count are discarded.
- Priority on each falling edge, highest first: rst, load, en, hold.
- load=1: q<=din regardless of en. ovf is unaffected except by ovf_clr.
- load=0, en=1:
  - if q==limit: q<=0 (wrap), ovf set.
  - else if q==2^WIDTH-1 (count above limit, e.g. after loading past it): q<=0 by natural rollover, ovf set.
  - else: q<=q+1, evaluated modulo 2^WIDTH with no carry-out beyond WIDTH.
- load=0, en=0: q holds.
- tc = en & ~load & (q==limit). It is combinational so that a cascaded stage's en sees the carry in the same cycle. tc=0 during reset.
- Natural rollover does not assert tc; only an equality match with limit does.
- ovf:
  - Set on any wrap to 0 (limit match or natural rollover).
  - Cleared by ovf_clr=1 on the falling edge.
  - If a wrap and ovf_clr occur on the same edge, set wins (ovf=1).
- limit=0 with en=1: q stays 0, tc=1 every cycle, ovf set on every edge.
- limit changes mid-count take effect on the next comparison, with no latching. If the new limit is below q, the counter runs to 2^WIDTH-1 and then rolls over.
- Latency: q and ovf update one falling edge after the inputs are sampled. tc has zero latency from q, en and load.
- No X propagation: every register has a reset value.

Decomposition:
- Shared package (counter_pkg): default WIDTH constant, RST_VAL constant, and an encoded next-action enum (ACT_HOLD, ACT_LOAD, ACT_INC, ACT_WRAP) used by both RTL and bench.
- One natural sub-module, cnt_next_state: combinational next-q, wrap and action decode from q, limit, din, en and load. The top level holds the negedge registers, the ovf logic and tc.

Test Plan (WIDTH=3, RST_VAL=0):
- Reset then count: rst low then high, limit=7, en=1 for 9 falling edges -> q steps 1..7 then 0 then 1. tc=1 only while q=7. ovf=1 from the wrap edge onward.
- Modulo limit: limit=4, en=1 -> q sequence 0,1,2,3,4,0,1. tc high only at q=4. Assert ovf_clr on the same edge as the 4->0 wrap -> ovf stays 1. ovf_clr on the next edge -> ovf=0.
- Load priority and load above limit: load=1, din=6, en=1, limit=3 -> q=6. Continue en=1 -> q=7, then 0 (rollover), ovf=1, tc never asserted.
- Enable gating: q=2, en=0 for 5 edges -> q stays 2, tc=0 even if limit=2. Raise en -> tc=1 combinationally, and the next edge gives q=0.
- Async reset mid-count: q=5, drop rst between edges -> q=0 and ovf=0 immediately. Edges while rst is low leave q=0. Release -> next edge gives q=1.
- limit=0: en=1 -> q=0 every edge, tc constantly 1, ovf=1. A two-stage cascade (stage B en driven by stage A tc, limit=7 each) -> B increments once per 8 A edges.
